// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared mode and step-direction constants for updown_counter
package counter_pkg;

  localparam int MODE_WRAP     = 0;
  localparam int MODE_SATURATE = 1;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/updown_counter_next.sv
// rtl/updown_counter_next.sv - combinational next-count and wrap decision
module updown_counter_next
  import counter_pkg::*;
#(
  parameter int          Size     = 5,
  parameter logic [32:0] Modulus  = 33'd1 << Size,
  parameter int          Saturate = MODE_WRAP
) (
  input  logic [Size-1:0] count_i,
  input  logic            enable_i,
  input  logic            up_i,
  input  logic            load_i,
  input  logic [Size-1:0] load_value_i,
  output logic [Size-1:0] next_count_o,
  output logic            next_wrap_o
);

  localparam logic [32:0]   MAX_FULL = Modulus - 33'd1;
  localparam logic [Size:0] MAX_VAL  = MAX_FULL[Size:0];
  localparam logic [Size:0] ONE      = (Size+1)'(1);

  // One extra bit keeps the +1 at the top of a full-range counter from overflowing.
  logic [Size:0] cnt_x;
  logic [Size:0] ld_x;
  logic [Size:0] nxt_x;
  logic          unused_msb;

  assign cnt_x = {1'b0, count_i};
  assign ld_x  = {1'b0, load_value_i};

  always_comb begin
    nxt_x       = cnt_x;
    next_wrap_o = 1'b0;
    if (load_i) begin
      nxt_x = (ld_x > MAX_VAL) ? MAX_VAL : ld_x;
    end else if (enable_i) begin
      if (up_i == DIR_UP) begin
        if (cnt_x < MAX_VAL) begin
          nxt_x = cnt_x + ONE;
        end else if (Saturate == MODE_WRAP) begin
          nxt_x       = '0;
          next_wrap_o = 1'b1;
        end
      end else if (up_i == DIR_DOWN) begin
        if (cnt_x != '0) begin
          nxt_x = cnt_x - ONE;
        end else if (Saturate == MODE_WRAP) begin
          nxt_x       = MAX_VAL;
          next_wrap_o = 1'b1;
        end
      end
    end
  end

  assign next_count_o = nxt_x[Size-1:0];
  assign unused_msb   = nxt_x[Size];

endmodule

// File: rtl/updown_counter.sv
// rtl/updown_counter.sv - modulo up/down counter; UPDOWN_COUNTER_STICKY_EN adds sticky wrap history
module updown_counter
  import counter_pkg::*;
#(
  parameter int          Size     = 5,
  parameter logic [32:0] Modulus  = 33'd1 << Size,
  parameter int          Saturate = MODE_WRAP
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            up,
  input  logic            load,
  input  logic [Size-1:0] load_value,
  output logic [Size-1:0] count,
  output logic            at_max,
  output logic            at_min,
  output logic            wrap
`ifdef UPDOWN_COUNTER_STICKY_EN
  ,
  input  logic            clear_sticky,
  output logic            sticky_wrap
`endif
);

  localparam logic [32:0]   MAX_FULL = Modulus - 33'd1;
  localparam logic [Size:0] MAX_VAL  = MAX_FULL[Size:0];

  logic [Size-1:0] count_q;
  logic [Size-1:0] count_d;
  logic            wrap_q;
  logic            wrap_d;

  updown_counter_next #(
    .Size     (Size),
    .Modulus  (Modulus),
    .Saturate (Saturate)
  ) u_next (
    .count_i      (count_q),
    .enable_i     (enable),
    .up_i         (up),
    .load_i       (load),
    .load_value_i (load_value),
    .next_count_o (count_d),
    .next_wrap_o  (wrap_d)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count  = count_q;
  assign wrap   = wrap_q;
  assign at_max = ({1'b0, count_q} == MAX_VAL);
  assign at_min = (count_q == '0);

`ifdef UPDOWN_COUNTER_STICKY_EN
  logic sticky_q;
  logic sticky_d;

  // A wrap landing on the same edge as a clear must not be lost.
  always_comb begin
    sticky_d = sticky_q;
    if (wrap_d) begin
      sticky_d = 1'b1;
    end else if (clear_sticky) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_wrap = sticky_q;
`else
  // wrap history is not retained in this build
`endif

endmodule

// File: tb/tb_updown_counter.sv
// tb/tb_updown_counter.sv - scoreboard bench for updown_counter over four modulus/mode variants
module tb_updown_counter;

  localparam int NDUT = 4;
  localparam int MODS [NDUT] = '{32, 10, 10, 4};
  localparam int SATS [NDUT] = '{0, 0, 1, 0};

  typedef struct packed {
    logic [NDUT-1:0][4:0] cnt;
    logic [NDUT-1:0]      wrp;
    logic [NDUT-1:0]      stk;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       up;
  logic       load;
  logic [4:0] load_value;
  logic       clear_sticky;

  logic [4:0] d_cnt [NDUT];
  logic       d_max [NDUT];
  logic       d_min [NDUT];
  logic       d_wrap[NDUT];
  logic       d_stk [NDUT];

  int m_cnt [NDUT];
  bit m_wrap[NDUT];
  bit m_stk [NDUT];

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    updown_counter #(
      .Size     (5),
      .Modulus  (33'(MODS[g])),
      .Saturate (SATS[g])
    ) u_dut (
      .clock        (clock),
      .reset        (reset),
      .enable       (enable),
      .up           (up),
      .load         (load),
      .load_value   (load_value),
      .count        (d_cnt[g]),
      .at_max       (d_max[g]),
      .at_min       (d_min[g]),
      .wrap         (d_wrap[g])
`ifdef UPDOWN_COUNTER_STICKY_EN
      ,
      .clear_sticky (clear_sticky),
      .sticky_wrap  (d_stk[g])
`endif
    );
`ifndef UPDOWN_COUNTER_STICKY_EN
    assign d_stk[g] = 1'b0;
`endif
  end

  // Reference: step by +/-1 in plain integers, then fold back into 0..m-1 or clamp.
  function automatic void model_next(input int c, input int m, input int s,
                                     input bit en, input bit u, input bit ld, input int lv,
                                     output int nc, output bit w);
    int t;
    nc = c;
    w  = 1'b0;
    if (ld) begin
      nc = (lv > m - 1) ? m - 1 : lv;
    end else if (en) begin
      t = c + (u ? 1 : -1);
      if (t < 0 || t >= m) begin
        if (s == 0) begin
          nc = (t + m) % m;
          w  = 1'b1;
        end
      end else begin
        nc = t;
      end
    end
  endfunction

  task automatic check(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic push_expected();
    exp_t e;
    for (int i = 0; i < NDUT; i++) begin
      e.cnt[i] = 5'(m_cnt[i]);
      e.wrp[i] = m_wrap[i];
      e.stk[i] = m_stk[i];
    end
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NDUT; i++) begin
      m_cnt[i]  = 0;
      m_wrap[i] = 1'b0;
      m_stk[i]  = 1'b0;
    end
  endtask

  task automatic step(input bit en, input bit u, input bit ld, input int lv, input bit clr);
    int nc;
    bit w;
    enable       = en;
    up           = u;
    load         = ld;
    load_value   = 5'(lv);
    clear_sticky = clr;
    @(posedge clock);
    for (int i = 0; i < NDUT; i++) begin
      model_next(m_cnt[i], MODS[i], SATS[i], en, u, ld, lv, nc, w);
      m_cnt[i]  = nc;
      m_wrap[i] = w;
      m_stk[i]  = w ? 1'b1 : (clr ? 1'b0 : m_stk[i]);
    end
    #1;
    push_expected();
  endtask

  // Drop reset between edges; the monitor samples before the next rising edge.
  task automatic async_reset_check();
    @(negedge clock);
    #2;
    model_reset();
    push_expected();
    reset = 1'b0;
    @(posedge clock);
    #1;
    push_expected();
    reset = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock or negedge reset);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < NDUT; i++) begin
          check($sformatf("count[%0d]", i), int'(d_cnt[i]), int'(e.cnt[i]));
          check($sformatf("wrap[%0d]", i), int'(d_wrap[i]), int'(e.wrp[i]));
          check($sformatf("at_max[%0d]", i), int'(d_max[i]), int'(int'(e.cnt[i]) == MODS[i] - 1));
          check($sformatf("at_min[%0d]", i), int'(d_min[i]), int'(e.cnt[i] == 5'd0));
`ifdef UPDOWN_COUNTER_STICKY_EN
          check($sformatf("sticky_wrap[%0d]", i), int'(d_stk[i]), int'(e.stk[i]));
`endif
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    reset        = 1'b0;
    enable       = 1'b0;
    up           = 1'b0;
    load         = 1'b0;
    load_value   = '0;
    clear_sticky = 1'b0;
    model_reset();
    repeat (2) begin
      @(posedge clock);
      #1;
      push_expected();
    end
    reset = 1'b1;

    repeat (33) step(1, 1, 0, 0, 0);

    step(0, 0, 1, 16, 0);
    step(1, 1, 0, 0, 0);
    async_reset_check();
    step(1, 1, 0, 0, 0);

    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    step(0, 0, 1, 0, 0);
    repeat (13) step(1, 1, 0, 0, 0);
    repeat (13) step(1, 0, 0, 0, 0);

    step(1, 1, 1, 25, 0);
    step(0, 0, 1, 4, 0);

    step(0, 0, 1, 3, 0);
    step(1, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    for (int k = 0; k < 1500; k++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 15) == 0, int'($urandom_range(0, 31)),
           $urandom_range(0, 7) == 0);
      if (k == 700) async_reset_check();
    end

    repeat (2) @(negedge clock);
    #3;
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
